fp_round_pack: RTL and testbench
================================

# fp_round_pack

Output stage of the single-precision floating-point adder. It sits directly downstream of `normaliseSum` and takes its normalised fraction and exponent, plus the result sign and the special-case flags from the unpack stage. It packs these into an IEEE754 single-precision word through a 2-stage valid/ready pipeline. It also handles zero, overflow, underflow and NaN/infinity outputs, keeps sticky exception flags, and counts delivered results.

## Interface
- No parameters; widths are fixed to single precision.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  upstream result present.
- `in_ready`  out  1  stage can accept; a transfer occurs when `in_valid && in_ready`.
- `frac_in`  in  32  normalised fraction from `normaliseSum`:
  - bit 23 is the hidden bit; bits [22:0] are the mantissa.
  - bits [31:24] are ignored.
- `exp_in`  in  8  biased exponent from `normaliseSum`.
- `sign_in`  in  1  result sign.
- `op_in`  in  1  0 = add, 1 = subtract (effective operation).
- `nan_in`  in  1  operand NaN, or inf − inf.
- `inf_in`  in  1  result is infinity by operand.
- `out_valid`  out  1  packed result present.
- `out_ready`  in  1  downstream accepts.
- `result`  out  32  IEEE754 word.
- `flags`  out  3  sticky {invalid, overflow, underflow}.
- `flag_clr`  in  1  synchronous clear of `flags`.
- `result_count`  out  16  number of delivered results; saturates at 0xFFFF.

## Operation
- Stage 1 registers the inputs and classifies the result. Priority is highest first:
  1. `nan_in` → class NAN.
  2. `inf_in` → class INF.
  3. `frac_in[23]==0` → class ZERO.
  4. `exp_in==8'hFF` → class OVF.
  5. `exp_in==8'h00` → class UNF.
  6. Otherwise → class NORM.
- Stage 2 registers `result` according to the class:
  - NAN: `32'h7FC00000`; sign is ignored.
  - INF: `{sign_in, 8'hFF, 23'd0}`.
  - ZERO: `{op_in ? 1'b0 : sign_in, 31'd0}`. An exact cancellation gives +0.
  - OVF: `{sign_in, 8'hFF, 23'd0}`.
  - UNF: `{sign_in, 31'd0}`. Denormals are flushed to zero.
  - NORM: `{sign_in, exp_in, frac_in[22:0]}`. Rounding is truncation, because the upstream datapath carries no guard bits.
- Flag setting happens when a result enters stage 2:
  - NAN sets `invalid`.
  - OVF sets `overflow`.
  - UNF sets `underflow`.
  - INF and ZERO set no flag.
- When `flag_clr` and a flag-setting entry occur in the same cycle, `flags` becomes the new entry's bits only.
- `result_count` increments on each `out_valid && out_ready` and holds at 0xFFFF.
- Pipeline control:
  - `s2_adv = !out_valid || out_ready`.
  - `s1_adv = !s1_valid || s2_adv`.
  - `in_ready = s1_adv` (combinational).
- A stalled stage holds its data and valid bit unchanged. `result` is stable while `out_valid && !out_ready`.

## Timing
- Reset (`rst_n` low, asynchronous) clears everything immediately:
  - `out_valid=0`, `result=0`, `flags=0`, `result_count=0`.
  - Stage 1 is emptied.
  - `in_ready=1` once the stage is empty.
- Reset asserted mid-operation discards all in-flight results and does not count them.
- Latency is 2 cycles. An input accepted at edge N appears on `result` with `out_valid=1` after edge N+1.
- Throughput is 1 result/cycle while `out_ready` is held high.
- With `out_ready` low, the pipeline holds 2 results and then deasserts `in_ready`:
  - Stage 2 fills, then stage 1 fills.
  - `in_ready` drops in the cycle after stage 1 fills.
- When a result leaves stage 2 and stage 1 advances in the same cycle, no bubble is inserted.
- `flag_clr` takes effect at the next edge. `flags` updates in the same edge that loads stage 2.

## Test plan
- Normal result: `sign=0`, `exp=8'h7F`, `frac=32'h00C00000`, op add → `result=32'h3FC00000` two cycles later, `flags=0`, `result_count=1`.
- Exact cancellation: op sub, `frac=0`, `sign=1` → `result=32'h00000000`. Same input with op add → `32'h80000000`.
- Exponent boundaries:
  - `exp=8'hFF`, `frac=32'h00800000`, `sign=1` → `32'hFF800000`, `flags=3'b010`.
  - `exp=8'h00`, `frac=32'h00800000` → `32'h00000000`, `flags` gains `3'b001`.
- NaN has priority: `nan_in=1`, `inf_in=1`, `exp=8'hFF` → `32'h7FC00000`, `flags=3'b100`.
- Backpressure:
  - Send 4 back-to-back results with `out_ready=0` → exactly 2 accepted, `in_ready=0`, `result` stable.
  - Raise `out_ready` → all 4 results delivered in order, `result_count=4`.
- Clear and reset collision:
  - `flag_clr` in the same cycle as an OVF entry → `flags=3'b010`.
  - `rst_n` pulsed low with 2 results in flight → `out_valid=0` and `flags=0` immediately, and `result_count=0`.

Source files
------------

// File: rtl/fp_round_pack.sv
`default_nettype none
// ============================================================================
//  Module      : fp_round_pack
//  Description : Output stage of the single-precision FP adder. Classifies
//                the normalised sum, packs it into an IEEE754 word through a
//                2-stage valid/ready pipeline, keeps sticky exception flags
//                and counts delivered results.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_round_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] frac_in,
    input  logic [7:0]  exp_in,
    input  logic        sign_in,
    input  logic        op_in,
    input  logic        nan_in,
    input  logic        inf_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [2:0]  flags,
    input  logic        flag_clr,
    output logic [15:0] result_count
);

    // Result classes, resolved in stage 1 and consumed by the stage 2 packer
    localparam logic [2:0] CLS_NAN  = 3'd0;
    localparam logic [2:0] CLS_INF  = 3'd1;
    localparam logic [2:0] CLS_ZERO = 3'd2;
    localparam logic [2:0] CLS_OVF  = 3'd3;
    localparam logic [2:0] CLS_UNF  = 3'd4;
    localparam logic [2:0] CLS_NORM = 3'd5;

    localparam logic [31:0] C_QNAN     = 32'h7FC0_0000;
    localparam logic [15:0] C_CNT_MAX  = 16'hFFFF;

    // Flag bit positions inside {invalid, overflow, underflow}
    localparam logic [2:0] C_FLG_INV = 3'b100;
    localparam logic [2:0] C_FLG_OVF = 3'b010;
    localparam logic [2:0] C_FLG_UNF = 3'b001;

    // Stage 1 registers
    logic        r_s1_valid;
    logic [2:0]  r_s1_cls;
    logic        r_s1_sign;
    logic        r_s1_op;
    logic [7:0]  r_s1_exp;
    logic [22:0] r_s1_mant;

    // Stage 2 / status registers
    logic        r_out_valid;
    logic [31:0] r_result;
    logic [2:0]  r_flags;
    logic [15:0] r_count;

    // Combinational control and datapath
    logic        w_s2_adv;
    logic        w_s1_adv;
    logic        w_s2_load;
    logic [2:0]  w_cls;
    logic [31:0] w_packed;
    logic [2:0]  w_new_flags;

    // Upper fraction bits carry no information for single precision
    logic        w_unused_frac;
    assign w_unused_frac = ^frac_in[31:24];

    // Pipeline advance: each stage moves when its successor has room
    assign w_s2_adv  = !r_out_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign w_s2_load = w_s2_adv && r_s1_valid;

    assign in_ready     = w_s1_adv;
    assign out_valid    = r_out_valid;
    assign result       = r_result;
    assign flags        = r_flags;
    assign result_count = r_count;

    // Classify the incoming result, highest-priority condition first
    always_comb begin
        w_cls = CLS_NORM;
        if (nan_in)
            w_cls = CLS_NAN;
        else if (inf_in)
            w_cls = CLS_INF;
        else if (!frac_in[23])
            w_cls = CLS_ZERO;
        else if (exp_in == 8'hFF)
            w_cls = CLS_OVF;
        else if (exp_in == 8'h00)
            w_cls = CLS_UNF;
    end

    // Stage 1: capture the classified operand whenever the stage advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_cls   <= CLS_ZERO;
            r_s1_sign  <= 1'b0;
            r_s1_op    <= 1'b0;
            r_s1_exp   <= 8'd0;
            r_s1_mant  <= 23'd0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_cls  <= w_cls;
                r_s1_sign <= sign_in;
                r_s1_op   <= op_in;
                r_s1_exp  <= exp_in;
                r_s1_mant <= frac_in[22:0];
            end
        end
    end

    // Pack the stage 1 contents into an IEEE754 word and its flag bits.
    // Rounding is truncation: the upstream datapath carries no guard bits.
    always_comb begin
        w_packed    = 32'd0;
        w_new_flags = 3'b000;
        case (r_s1_cls)
            CLS_NAN: begin
                w_packed    = C_QNAN;
                w_new_flags = C_FLG_INV;
            end
            CLS_INF: begin
                w_packed = {r_s1_sign, 8'hFF, 23'd0};
            end
            CLS_ZERO: begin
                // An exact cancellation of a subtraction yields +0
                w_packed = {(r_s1_op ? 1'b0 : r_s1_sign), 31'd0};
            end
            CLS_OVF: begin
                w_packed    = {r_s1_sign, 8'hFF, 23'd0};
                w_new_flags = C_FLG_OVF;
            end
            CLS_UNF: begin
                // Denormals are flushed to a signed zero
                w_packed    = {r_s1_sign, 31'd0};
                w_new_flags = C_FLG_UNF;
            end
            default: begin
                w_packed = {r_s1_sign, r_s1_exp, r_s1_mant};
            end
        endcase
    end

    // Stage 2: output register, held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= 32'd0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid)
                r_result <= w_packed;
        end
    end

    // Sticky flags; a clear coinciding with a load keeps only the new bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_flags <= 3'b000;
        else if (flag_clr)
            r_flags <= w_s2_load ? w_new_flags : 3'b000;
        else if (w_s2_load)
            r_flags <= r_flags | w_new_flags;
    end

    // Saturating count of results accepted downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= 16'd0;
        else if (r_out_valid && out_ready && (r_count != C_CNT_MAX))
            r_count <= r_count + 16'd1;
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_round_pack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_round_pack
//  Description : Self-checking bench for fp_round_pack: directed literal
//                cases plus randomized traffic compared every cycle against
//                a queue-based behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_round_pack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] frac_in = 32'd0;
    logic [7:0]  exp_in = 8'd0;
    logic        sign_in = 1'b0;
    logic        op_in = 1'b0;
    logic        nan_in = 1'b0;
    logic        inf_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [2:0]  flags;
    logic        flag_clr = 1'b0;
    logic [15:0] result_count;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    fp_round_pack dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .frac_in      (frac_in),
        .exp_in       (exp_in),
        .sign_in      (sign_in),
        .op_in        (op_in),
        .nan_in       (nan_in),
        .inf_in       (inf_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .flags        (flags),
        .flag_clr     (flag_clr),
        .result_count (result_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] r;
        logic [2:0]  f;
    } ent_t;

    function automatic ent_t ref_pack(input logic s, input logic o, input logic n,
                                      input logic i, input logic [7:0] e, input logic [31:0] fr);
        ent_t x;
        x.f = 3'b000;
        if (n) begin
            x.r = 32'h7FC00000; x.f = 3'b100;
        end else if (i) begin
            x.r = {s, 8'hFF, 23'd0};
        end else if (!fr[23]) begin
            x.r = {(o ? 1'b0 : s), 31'd0};
        end else if (e == 8'hFF) begin
            x.r = {s, 8'hFF, 23'd0}; x.f = 3'b010;
        end else if (e == 8'h00) begin
            x.r = {s, 31'd0}; x.f = 3'b001;
        end else begin
            x.r = {s, e, fr[22:0]};
        end
        return x;
    endfunction

    // q holds every accepted, undelivered result; m_ov says whether the
    // oldest one is already presented on the output.
    ent_t        q[$];
    bit          m_ov;
    logic [2:0]  m_flags;
    logic [15:0] m_count;

    function automatic bit model_in_ready();
        bit s1_has;
        s1_has = q.size() > (m_ov ? 1 : 0);
        return !s1_has || !m_ov || out_ready;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_ov    = 1'b0;
            m_flags = 3'b000;
            m_count = 16'd0;
        end else begin
            bit s1_has, s2_free, acc, entry;
            logic [2:0] bits;
            s1_has  = q.size() > (m_ov ? 1 : 0);
            s2_free = !m_ov || out_ready;
            acc     = in_valid && (!s1_has || s2_free);
            entry   = 1'b0;
            bits    = 3'b000;
            if (m_ov && out_ready) begin
                void'(q.pop_front());
                if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
                m_ov = 1'b0;
            end
            if (s2_free && s1_has) begin
                entry = 1'b1;
                bits  = q[0].f;
                m_ov  = 1'b1;
            end
            if (flag_clr) m_flags = entry ? bits : 3'b000;
            else          m_flags = m_flags | bits;
            if (acc) q.push_back(ref_pack(sign_in, op_in, nan_in, inf_in, exp_in, frac_in));
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_ov});
            chk("m_in_ready", {31'd0, in_ready}, {31'd0, model_in_ready()});
            chk("m_flags", {29'd0, flags}, {29'd0, m_flags});
            chk("m_count", {16'd0, result_count}, {16'd0, m_count});
            if (!rst_n)
                chk("m_result_rst", result, 32'd0);
            else if (m_ov && q.size() > 0)
                chk("m_result", result, q[0].r);
        end
    end

    // ---------------- directed helpers ----------------
    // Called aligned at posedge+#1; sends one item with out_ready high.
    task automatic send1(input string name, input logic s, input logic o, input logic n,
                         input logic i, input logic [7:0] e, input logic [31:0] fr,
                         input logic clr, input logic [31:0] exp_res);
        sign_in = s; op_in = o; nan_in = n; inf_in = i; exp_in = e; frac_in = fr;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flag_clr = clr;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk(name, result, exp_res);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_flags", {29'd0, flags}, 32'd0);
        chk("rst_count", {16'd0, result_count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [31:0] bp_exp [4];

    initial begin
        bp_exp[0] = 32'h40000000;
        bp_exp[1] = 32'h40800001;
        bp_exp[2] = 32'h41000002;
        bp_exp[3] = 32'h41800003;

        #1 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_result", result, 32'd0);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_flags", {29'd0, flags}, 32'd0);
        chk("reset_count", {16'd0, result_count}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed literal cases
        send1("normal", 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F, 32'h00C00000, 1'b0, 32'h3FC00000);
        chk("normal_flags", {29'd0, flags}, 32'd0);
        chk("normal_count", {16'd0, result_count}, 32'd1);
        send1("cancel_sub", 1'b1, 1'b1, 1'b0, 1'b0, 8'h7F, 32'h00000000, 1'b0, 32'h00000000);
        send1("zero_add", 1'b1, 1'b0, 1'b0, 1'b0, 8'h7F, 32'h00000000, 1'b0, 32'h80000000);
        send1("ovf", 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 32'h00800000, 1'b0, 32'hFF800000);
        chk("ovf_flags", {29'd0, flags}, 32'b010);
        send1("unf", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h00800000, 1'b0, 32'h00000000);
        chk("unf_flags", {29'd0, flags}, 32'b011);
        flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        chk("clr_flags", {29'd0, flags}, 32'd0);
        send1("nan_prio", 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 32'h00800000, 1'b0, 32'h7FC00000);
        chk("nan_flags", {29'd0, flags}, 32'b100);
        send1("clr_ovf", 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 32'h00800000, 1'b1, 32'h7F800000);
        chk("clr_ovf_flags", {29'd0, flags}, 32'b010);

        // Backpressure: 4 back-to-back items against a stalled output
        pulse_reset();
        out_ready = 1'b0;
        begin
            int acc = 0;
            int got = 0;
            bit w;
            logic [31:0] held;
            for (int c = 0; c < 4; c++) begin
                sign_in = 1'b0; op_in = 1'b0; nan_in = 1'b0; inf_in = 1'b0;
                exp_in = 8'h80 + 8'(acc); frac_in = 32'h00800000 | acc;
                in_valid = 1'b1;
                #1 w = in_ready;
                @(posedge clk); #1;
                if (w) acc++;
            end
            chk("bp_accepted", acc, 32'd2);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            held = result;
            repeat (2) @(posedge clk);
            #1;
            chk("bp_stable", result, held);
            chk("bp_head", result, bp_exp[0]);
            out_ready = 1'b1;
            for (int c = 0; c < 20 && got < 4; c++) begin
                if (acc < 4) begin
                    exp_in = 8'h80 + 8'(acc); frac_in = 32'h00800000 | acc;
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                #1;
                if (out_valid && got < 4) begin
                    chk("bp_order", result, bp_exp[got]);
                    got++;
                end
                w = in_valid && in_ready;
                @(posedge clk); #1;
                if (w) acc++;
            end
            in_valid = 1'b0;
            chk("bp_delivered", got, 32'd4);
            chk("bp_count", {16'd0, result_count}, 32'd4);
        end

        // Reset with two results in flight
        out_ready = 1'b0;
        sign_in = 1'b0; exp_in = 8'hFF; frac_in = 32'h00800000; in_valid = 1'b1;
        @(posedge clk); #1;
        exp_in = 8'h10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("inflight_flags", {29'd0, flags}, 32'b010);
        chk("inflight_valid", {31'd0, out_valid}, 32'd1);
        pulse_reset();
        out_ready = 1'b1;

        // Randomized traffic checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            int sel;
            sel      = $urandom_range(0, 9);
            exp_in   = (sel == 0) ? 8'hFF : (sel == 1) ? 8'h00 : 8'($urandom);
            frac_in  = $urandom;
            if ($urandom_range(0, 7) != 0) frac_in[23] = 1'b1;
            sign_in  = 1'($urandom);
            op_in    = 1'($urandom);
            nan_in   = ($urandom_range(0, 15) == 0);
            inf_in   = ($urandom_range(0, 15) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flag_clr = ($urandom_range(0, 19) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        flag_clr = 1'b0;
        repeat (4) @(posedge clk);
        #1 cmp_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
